calendar_date_counter: RTL and testbench
========================================

Name: calendar_date_counter

Overview:
- Binary day/month/year counter for the calendar datapath, advanced by a once-per-day tick from the time-of-day counter.
- Sits directly upstream of the 8-bit binary-to-BCD converters: day_out and month_out are 8-bit binary values fed straight into them.
- Handles days-per-month, Gregorian leap years and year wrap.
- Accepts a validated date-set request through a multi-cycle leap-residue computation.

Parameters:
- YEAR_W, 14: year counter width; year range 0..2^YEAR_W-1.
- RESET_YEAR, 2000: year loaded at reset; residues mod 4/100/400 are computed at elaboration.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- tick_day  input  1  single-cycle pulse, advance date by one day.
- set_en  input  1  single-cycle pulse, request load of set_* values.
- set_year  input  YEAR_W  requested year.
- set_month  input  4  requested month, 1..12.
- set_day  input  5  requested day, 1..31.
- day_out  output  8  current day, binary, 1..31.
- month_out  output  8  current month, binary, 1..12.
- year_out  output  YEAR_W  current year, binary.
- leap  output  1  current year is a leap year.
- busy  output  1  set request in progress.
- set_err  output  1  single-cycle pulse, set request rejected.
- year_roll  output  1  single-cycle pulse, Dec 31 -> Jan 1 occurred.

Behaviour:
- One clock: clk. Reset: rst_n, synchronous, active-low.
- Reset values:
  - day_out=1, month_out=1, year_out=RESET_YEAR.
  - Residues r4/r100/r400 = RESET_YEAR mod 4/100/400; leap derived from them.
  - busy=0, set_err=0, year_roll=0, pending tick cleared, FSM=RUN.
  - Reset mid-set aborts the set with no commit.
- leap = (r4==0) && (r100!=0 || r400==0). Combinational from the registered residues; never computed with a divider.
- dim (days in month):
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - Feb: 29 if leap, else 28.
- Tick in RUN, outputs updated on the same edge:
  - day<dim: day+1.
  - day==dim, month<12: day=1, month+1.
  - day==dim, month==12: day=1, month=1, year+1.
    - r4/r100/r400 each increment with wrap at 3/99/399.
    - year_roll pulses for 1 cycle.
- Year wrap: at year 2^YEAR_W-1, next year is 0 and all residues reset to 0, so year 0 is leap.
- FSM states: RUN, CALC400, CALC100, CHECK.
  - RUN + set_en: capture set_* into staging regs and rem=set_year; go to CALC400; busy=1 from next cycle.
  - CALC400: each cycle, if rem>=400 then rem-=400; else s400=rem, go to CALC100.
  - CALC100: each cycle, if rem>=100 then rem-=100; else go to CHECK.
  - The staged r4 comes from the low two bits of the staged year, not of rem.
  - CHECK: valid iff 1<=month<=12 and 1<=day<=dim(staged month, staged leap).
    - Valid: commit staged values and residues to the outputs.
    - Invalid: pulse set_err; outputs unchanged.
    - Either way, return to RUN with busy=0 on the same edge.
- busy duration: k400+k100+3 cycles, where k400=floor(Y/400) and k100=floor((Y mod 400)/100). Example: Y=2024 gives 8 cycles.
- Outputs hold their old values throughout busy.
- set_en while busy: ignored.
- set_en and tick_day in the same RUN cycle: set wins; the tick becomes pending.
- tick_day while busy: sets the pending flag (max one; further ticks are dropped). The pending tick is applied on the first RUN cycle after CHECK, to the committed or retained date.

Optional Feature:
- Macro: CALENDAR_WEEKDAY_EN.
- Defined:
  - Adds input set_wday[2:0] and output wday_out[2:0], 0=Sunday..6=Saturday; reset value = elaboration parameter RESET_WDAY, default 6 (Sat, 1 Jan 2000).
  - Each applied tick increments wday_out with wrap 6->0.
  - set_wday is staged with the set and committed only on valid CHECK; set_wday>6 is rejected via set_err.
- Undefined: no ports, no weekday logic.

Test Plan:
- Reset low 2 cycles -> 01/01/2000, leap=1, busy=0, all pulses 0.
- Set 2023-02-28, then tick -> 2023-03-01; set 2024-02-28, then two ticks -> 29 Feb, then 01 Mar.
- Set 2100-02-28, then tick -> 2100-03-01, leap=0; set 2000-02-29 -> accepted, no set_err.
- Set 1999-12-31, then tick -> 2000-01-01 and year_roll high exactly 1 cycle.
- Set 2023-02-29 from 2024-05-05 -> set_err 1 cycle at CHECK; outputs stay 2024-05-05. Also set month 13 -> set_err.
- Set 2024-06-30, with tick_day on the 3rd busy cycle -> busy exactly 8 cycles, commit, then 2024-07-01 one cycle later.

Source files
------------

// File: rtl/calendar_date_counter.sv
// calendar_date_counter: binary day/month/year counter with Gregorian leap years and a validated multi-cycle date set
// Ports: clk, rst_n (sync active-low); tick_day advances one day; set_en/set_year/set_month/set_day request a date load;
// day_out/month_out/year_out current date; leap current-year flag; busy set in progress; set_err/year_roll one-cycle pulses.
// Optional weekday tracking (set_wday/wday_out, RESET_WDAY) is enabled by defining CALENDAR_WEEKDAY_EN.
module calendar_date_counter #(
  parameter int YEAR_W = 14,
  parameter int RESET_YEAR = 2000
`ifdef CALENDAR_WEEKDAY_EN
  , parameter int RESET_WDAY = 6
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_day,
  input  logic              set_en,
  input  logic [YEAR_W-1:0] set_year,
  input  logic [3:0]        set_month,
  input  logic [4:0]        set_day,
`ifdef CALENDAR_WEEKDAY_EN
  input  logic [2:0]        set_wday,
  output logic [2:0]        wday_out,
`endif
  output logic [7:0]        day_out,
  output logic [7:0]        month_out,
  output logic [YEAR_W-1:0] year_out,
  output logic              leap,
  output logic              busy,
  output logic              set_err,
  output logic              year_roll
);
  typedef enum logic [1:0] {RUN, CALC400, CALC100, CHECK} state_t;
  localparam logic [1:0] R4 = 2'(RESET_YEAR % 4);
  localparam logic [6:0] R100 = 7'(RESET_YEAR % 100);
  localparam logic [8:0] R400 = 9'(RESET_YEAR % 400);
  localparam logic [YEAR_W-1:0] YMAX = '1;
  state_t state, state_n;
  logic [4:0] day, st_day;
  logic [3:0] month, st_month;
  logic [YEAR_W-1:0] year, st_year, rem;
  logic [1:0] r4;
  logic [6:0] r100;
  logic [8:0] r400, s400;
  logic pend, apply, last_day, st_leap, valid;
`ifdef CALENDAR_WEEKDAY_EN
  logic [2:0] wday, st_wday;
  assign wday_out = wday;
`endif
  function automatic logic [4:0] dim(input logic [3:0] m, input logic lp);
    return m == 4'd2 ? (lp ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  assign day_out = {3'b0, day};
  assign month_out = {4'b0, month};
  assign year_out = year;
  assign busy = state != RUN;
  assign leap = r4 == 2'd0 && (r100 != 7'd0 || r400 == 9'd0);
  assign last_day = day == dim(month, leap);
  // a set request takes priority over a tick; a held-off tick is replayed from pend
  assign apply = state == RUN && !set_en && (tick_day || pend);
  // in CHECK, rem already holds the staged year mod 100
  assign st_leap = st_year[1:0] == 2'd0 && (rem != '0 || s400 == 9'd0);
`ifdef CALENDAR_WEEKDAY_EN
  assign valid = st_month >= 4'd1 && st_month <= 4'd12 && st_day >= 5'd1 &&
                 st_day <= dim(st_month, st_leap) && st_wday <= 3'd6;
`else
  assign valid = st_month >= 4'd1 && st_month <= 4'd12 && st_day >= 5'd1 &&
                 st_day <= dim(st_month, st_leap);
`endif
  always_comb begin
    state_n = state;
    case (state)
      RUN:     state_n = set_en ? CALC400 : RUN;
      CALC400: state_n = int'(rem) < 400 ? CALC100 : CALC400;
      CALC100: state_n = int'(rem) < 100 ? CHECK : CALC100;
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk) state <= !rst_n ? RUN : state_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      day <= 5'd1;
      month <= 4'd1;
      year <= YEAR_W'(RESET_YEAR);
      r4 <= R4;
      r100 <= R100;
      r400 <= R400;
      pend <= 1'b0;
      set_err <= 1'b0;
      year_roll <= 1'b0;
      st_day <= 5'd0;
      st_month <= 4'd0;
      st_year <= '0;
      rem <= '0;
      s400 <= 9'd0;
`ifdef CALENDAR_WEEKDAY_EN
      wday <= 3'(RESET_WDAY);
      st_wday <= 3'd0;
`endif
    end else begin
      pend <= apply ? (pend && tick_day) : (pend || tick_day);
      set_err <= state == CHECK && !valid;
      year_roll <= apply && last_day && month == 4'd12;
      if (state == RUN && set_en) begin
        st_day <= set_day;
        st_month <= set_month;
        st_year <= set_year;
        rem <= set_year;
`ifdef CALENDAR_WEEKDAY_EN
        st_wday <= set_wday;
`endif
      end
      if (state == CALC400) begin
        if (int'(rem) >= 400) rem <= rem - YEAR_W'(400);
        else s400 <= 9'(rem);
      end
      if (state == CALC100 && int'(rem) >= 100) rem <= rem - YEAR_W'(100);
      if (state == CHECK && valid) begin
        day <= st_day;
        month <= st_month;
        year <= st_year;
        r4 <= st_year[1:0];
        r100 <= 7'(rem);
        r400 <= s400;
`ifdef CALENDAR_WEEKDAY_EN
        wday <= st_wday;
`endif
      end
      if (apply) begin
        day <= last_day ? 5'd1 : day + 5'd1;
`ifdef CALENDAR_WEEKDAY_EN
        wday <= wday == 3'd6 ? 3'd0 : wday + 3'd1;
`endif
        if (last_day) month <= month == 4'd12 ? 4'd1 : month + 4'd1;
        if (last_day && month == 4'd12) begin
          year <= year + YEAR_W'(1);
          // wrapping to year 0 restarts every residue so year 0 counts as leap
          r4 <= year == YMAX ? 2'd0 : r4 + 2'd1;
          r100 <= (year == YMAX || r100 == 7'd99) ? 7'd0 : r100 + 7'd1;
          r400 <= (year == YMAX || r400 == 9'd399) ? 9'd0 : r400 + 9'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_calendar_date_counter.sv
// tb_calendar_date_counter: directed plus randomized checks of calendar_date_counter against a date-level model
module tb_calendar_date_counter;
  logic clk = 1'b0, rst_n = 1'b0, tick_day = 1'b0, set_en = 1'b0;
  logic [13:0] set_year = '0;
  logic [3:0] set_month = '0;
  logic [4:0] set_day = '0;
  logic [7:0] day_out, month_out;
  logic [13:0] year_out;
  logic leap, busy, set_err, year_roll;
  int checks = 0, errors = 0;
  bit chk_on = 0;
  int md = 1, mm = 1, my = 2000, cnt = 0, sy = 0, sm = 0, sd = 0;
  bit mpend = 0, merr = 0, mroll = 0;

  calendar_date_counter dut (
    .clk(clk), .rst_n(rst_n), .tick_day(tick_day), .set_en(set_en),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .day_out(day_out), .month_out(month_out), .year_out(year_out),
    .leap(leap), .busy(busy), .set_err(set_err), .year_roll(year_roll)
  );

  always #5 clk = ~clk;

  function automatic bit leapf(input int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int dimf(input int m, input int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    return (m == 2 && leapf(y)) ? 29 : t[m-1];
  endfunction

  always @(posedge clk) begin : model
    int d, m, y, c, ty, tm, td;
    bit p, e, r;
    d = md; m = mm; y = my; c = cnt; p = mpend; ty = sy; tm = sm; td = sd; e = 0; r = 0;
    if (!rst_n) begin
      d = 1; m = 1; y = 2000; c = 0; p = 0;
    end else if (c == 0) begin
      if (set_en) begin
        ty = int'(set_year); tm = int'(set_month); td = int'(set_day);
        c = ty / 400 + (ty % 400) / 100 + 3;
        p = p | tick_day;
      end else if (tick_day || p) begin
        p = p && tick_day;
        if (d < dimf(m, y)) d = d + 1;
        else begin
          d = 1;
          if (m < 12) m = m + 1;
          else begin m = 1; y = (y + 1) % 16384; r = 1; end
        end
      end
    end else begin
      p = p | tick_day;
      c = c - 1;
      if (c == 0) begin
        if (tm >= 1 && tm <= 12 && td >= 1 && td <= dimf(tm, ty)) begin
          d = td; m = tm; y = ty;
        end else e = 1;
      end
    end
    md <= d; mm <= m; my <= y; cnt <= c; mpend <= p; sy <= ty; sm <= tm; sd <= td;
    merr <= e; mroll <= r;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [33:0] got, exp;
      got = {day_out, month_out, year_out, leap, busy, set_err, year_roll};
      exp = {8'(md), 8'(mm), 14'(my), leapf(my), cnt != 0, merr, mroll};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model t=%0t got d=%0d m=%0d y=%0d leap=%b busy=%b err=%b roll=%b want d=%0d m=%0d y=%0d leap=%b busy=%b err=%b roll=%b",
                 $time, day_out, month_out, year_out, leap, busy, set_err, year_roll,
                 md, mm, my, leapf(my), cnt != 0, merr, mroll);
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    lit("idle_timeout", int'(busy), 0);
  endtask

  task automatic do_set(input int y, input int m, input int d);
    set_en = 1; set_year = 14'(y); set_month = 4'(m); set_day = 5'(d);
    @(negedge clk);
    set_en = 0;
    wait_idle();
  endtask

  task automatic tick();
    tick_day = 1;
    @(negedge clk);
    tick_day = 0;
  endtask

  task automatic lit_date(input string name, input int d, input int m, input int y);
    lit({name, "_day"}, int'(day_out), d);
    lit({name, "_month"}, int'(month_out), m);
    lit({name, "_year"}, int'(year_out), y);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_on = 1;
    lit_date("reset", 1, 1, 2000);
    lit("reset_leap", int'(leap), 1);
    lit("reset_busy", int'(busy), 0);
    rst_n = 1;
    do_set(2023, 2, 28); tick(); lit_date("feb_end_2023", 1, 3, 2023);
    do_set(2024, 2, 28); tick(); lit_date("feb28_2024", 29, 2, 2024);
    tick(); lit_date("feb29_2024", 1, 3, 2024);
    do_set(2100, 2, 28); tick(); lit_date("feb_2100", 1, 3, 2100);
    lit("leap_2100", int'(leap), 0);
    do_set(2000, 2, 29); lit("set_2000_err", int'(set_err), 0); lit_date("set_2000", 29, 2, 2000);
    do_set(1999, 12, 31); tick(); lit_date("roll", 1, 1, 2000);
    lit("roll_pulse", int'(year_roll), 1);
    @(negedge clk); lit("roll_pulse_end", int'(year_roll), 0);
    do_set(2024, 5, 5);
    do_set(2023, 2, 29); lit("bad_feb_err", int'(set_err), 1); lit_date("bad_feb", 5, 5, 2024);
    @(negedge clk); lit("bad_feb_err_end", int'(set_err), 0);
    do_set(2024, 13, 1); lit("bad_month_err", int'(set_err), 1);
    set_en = 1; set_year = 14'd2024; set_month = 4'd6; set_day = 5'd30;
    @(negedge clk);
    set_en = 0; n = 0;
    while (busy && n < 50) begin n++; tick_day = (n == 3); @(negedge clk); end
    tick_day = 0;
    lit("busy_len_2024", n, 8);
    lit_date("pend_commit", 30, 6, 2024);
    @(negedge clk); lit_date("pend_apply", 1, 7, 2024);
    do_set(16383, 12, 31); tick(); lit_date("wrap", 1, 1, 0);
    lit("wrap_leap", int'(leap), 1);
    set_en = 1; set_year = 14'd2050; set_month = 4'd3; set_day = 5'd3;
    @(negedge clk); set_en = 0; @(negedge clk);
    rst_n = 0; @(negedge clk); rst_n = 1;
    lit_date("abort", 1, 1, 2000); lit("abort_busy", int'(busy), 0);
    for (int i = 0; i < 4000; i++) begin
      tick_day = ($urandom_range(0, 3) == 0);
      set_en = ($urandom_range(0, 39) == 0);
      set_year = ($urandom_range(0, 3) == 0) ? 14'(16380 + $urandom_range(0, 3)) : 14'($urandom_range(0, 16383));
      set_month = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 12));
      set_day = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 31));
      @(negedge clk);
    end
    tick_day = 0; set_en = 0;
    repeat (60) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
